// File: rtl/data_mem_pkg.sv
// Shared types for the data memory controller: access sizes, FSM states and
// the word-offset width helper.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic int unsigned off_bits(input int unsigned data_bits);
    return $clog2(data_bits / 8);
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Combinational lane logic: alignment/size checking, big-endian store lane
// placement and load extraction with sign/zero extension.
module data_mem_align
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned OFF       = 2
) (
  input  logic [1:0]             i_st_size,
  input  logic [OFF-1:0]         i_st_off,
  input  logic [DATA_BITS-1:0]   i_st_wdata,
  output logic                   o_st_err,
  output logic [DATA_BITS/8-1:0] o_st_lane_en,
  output logic [DATA_BITS-1:0]   o_st_lanes,
  input  logic [1:0]             i_ld_size,
  input  logic [OFF-1:0]         i_ld_off,
  input  logic                   i_ld_signed,
  input  logic [DATA_BITS-1:0]   i_ld_word,
  output logic [DATA_BITS-1:0]   o_ld_data
);
  localparam int unsigned NB   = DATA_BITS / 8;
  localparam int unsigned PADW = $clog2(DATA_BITS);

  function automatic logic bad_access(input logic [1:0] sz, input logic [OFF-1:0] off);
    logic [2:0] o3;
    o3 = '0;
    o3[OFF-1:0] = off;
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return o3[0];
      SZ_WORD: return o3[1:0] != 2'b00;
      default: return (NB != 8) || (o3 != 3'b000);
    endcase
  endfunction

  // Byte distance from the accessed field's LSB lane to the word LSB;
  // lane 0 is the most significant byte.
  function automatic logic [OFF-1:0] lane_shift(input logic [1:0] sz, input logic [OFF-1:0] off);
    if (bad_access(sz, off)) return '0;
    return OFF'(NB - 32'(off) - (32'd1 << sz));
  endfunction

  logic [OFF-1:0]              w_st_sh;
  logic [OFF-1:0]              w_ld_sh;
  logic [PADW-1:0]             w_ld_pad;
  logic [DATA_BITS-1:0]        w_ld_left;
  logic signed [DATA_BITS-1:0] w_ld_sleft;

  always_comb begin
    o_st_err   = bad_access(i_st_size, i_st_off);
    w_st_sh    = lane_shift(i_st_size, i_st_off);
    o_st_lanes = i_st_wdata << {w_st_sh, 3'b000};
    o_st_lane_en = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      o_st_lane_en[i] = !o_st_err && (i >= 32'(i_st_off)) &&
                        (i < 32'(i_st_off) + (32'd1 << i_st_size));
    end
  end

  // Left-justify the field, then shift back down arithmetically or logically.
  always_comb begin
    w_ld_sh    = lane_shift(i_ld_size, i_ld_off);
    w_ld_pad   = PADW'(DATA_BITS - (32'd8 << i_ld_size));
    w_ld_left  = (i_ld_word >> {w_ld_sh, 3'b000}) << w_ld_pad;
    w_ld_sleft = w_ld_left;
    if (bad_access(i_ld_size, i_ld_off)) begin
      o_ld_data = '0;
    end else if (i_ld_signed) begin
      o_ld_data = w_ld_sleft >>> w_ld_pad;
    end else begin
      o_ld_data = w_ld_left >> w_ld_pad;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory with valid/ready request, fixed response latency and
// big-endian byte/half/word/dword access.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_rdata,
  output logic                 resp_err
);
  localparam int unsigned OFF      = off_bits(DATA_BITS);
  localparam int unsigned NB       = DATA_BITS / 8;
  localparam int unsigned DEPTH    = 2 ** (ADDR_BITS - OFF);
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);
  localparam logic        LAT1     = (LATENCY == 1);

  logic [DATA_BITS-1:0] r_mem [DEPTH];

  state_e               r_state, w_state_nxt;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic                 w_accept, w_fire;

  logic                 r_cap_write, r_cap_signed, r_cap_err;
  logic [1:0]           r_cap_size;
  logic [OFF-1:0]       r_cap_off;
  logic [DATA_BITS-1:0] r_cap_word;

  logic                 r_resp_valid, r_resp_err;
  logic [DATA_BITS-1:0] r_resp_rdata;

  logic [ADDR_BITS-OFF-1:0] w_idx;
  logic [OFF-1:0]           w_off;
  logic [DATA_BITS-1:0]     w_rd_word, w_upd_word, w_live_word;
  logic                     w_req_err;
  logic [NB-1:0]            w_lane_en;
  logic [DATA_BITS-1:0]     w_st_lanes, w_ld_data;

  logic                     w_src_write, w_src_signed, w_src_err;
  logic [1:0]               w_src_size;
  logic [OFF-1:0]           w_src_off;
  logic [DATA_BITS-1:0]     w_src_word;

  assign w_idx     = req_addr[ADDR_BITS-1:OFF];
  assign w_off     = req_addr[OFF-1:0];
  assign w_rd_word = r_mem[w_idx];

  always_comb begin
    w_upd_word = w_rd_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_lane_en[i]) w_upd_word[DATA_BITS-1-8*i -: 8] = w_st_lanes[DATA_BITS-1-8*i -: 8];
    end
  end

  assign w_live_word = req_write ? w_upd_word : w_rd_word;

  // With single-cycle latency the response is formed from the live request
  // at the acceptance edge; otherwise from the captured copy.
  assign w_src_write  = LAT1 ? req_write   : r_cap_write;
  assign w_src_size   = LAT1 ? req_size    : r_cap_size;
  assign w_src_off    = LAT1 ? w_off       : r_cap_off;
  assign w_src_signed = LAT1 ? req_signed  : r_cap_signed;
  assign w_src_err    = LAT1 ? w_req_err   : r_cap_err;
  assign w_src_word   = LAT1 ? w_live_word : r_cap_word;

  data_mem_align #(
    .DATA_BITS (DATA_BITS),
    .OFF       (OFF)
  ) u_align (
    .i_st_size    (req_size),
    .i_st_off     (w_off),
    .i_st_wdata   (req_wdata),
    .o_st_err     (w_req_err),
    .o_st_lane_en (w_lane_en),
    .o_st_lanes   (w_st_lanes),
    .i_ld_size    (w_src_size),
    .i_ld_off     (w_src_off),
    .i_ld_signed  (w_src_signed),
    .i_ld_word    (w_src_word),
    .o_ld_data    (w_ld_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    req_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LAT1) begin
            w_fire = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 3'd1) begin
          w_fire      = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_cap_write  <= 1'b0;
      r_cap_signed <= 1'b0;
      r_cap_err    <= 1'b0;
      r_cap_size   <= '0;
      r_cap_off    <= '0;
      r_cap_word   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_resp_valid <= w_fire;
      if (w_accept) begin
        r_cap_write  <= req_write;
        r_cap_signed <= req_signed;
        r_cap_err    <= w_req_err;
        r_cap_size   <= req_size;
        r_cap_off    <= w_off;
        r_cap_word   <= w_live_word;
      end
      if (w_fire) begin
        r_resp_err   <= w_src_err;
        r_resp_rdata <= w_src_err ? '0 : (w_src_write ? w_src_word : w_ld_data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_req_err) r_mem[w_idx] <= w_upd_word;
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed and randomized checks of data_mem_ctrl across four builds against a
// byte-addressed big-endian reference memory.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rstn, vld;
  wire  [3:0]  rdy, rv, re;
  wire  [31:0] rd0, rd1, rd2;
  wire  [63:0] rd3;

  logic        req_write, req_signed;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;

  int vectors, miscompares;
  logic [7:0] mref [4][4096];

  data_mem_ctrl #(.DATA_BITS(32), .ADDR_BITS(12), .LATENCY(1)) u0 (
    .clk(clk), .rst_n(rstn[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(rv[0]), .resp_rdata(rd0), .resp_err(re[0]));

  data_mem_ctrl #(.DATA_BITS(32), .ADDR_BITS(12), .LATENCY(4)) u1 (
    .clk(clk), .rst_n(rstn[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(rv[1]), .resp_rdata(rd1), .resp_err(re[1]));

  data_mem_ctrl #(.DATA_BITS(32), .ADDR_BITS(12), .LATENCY(3)) u2 (
    .clk(clk), .rst_n(rstn[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(rv[2]), .resp_rdata(rd2), .resp_err(re[2]));

  data_mem_ctrl #(.DATA_BITS(64), .ADDR_BITS(12), .LATENCY(2)) u3 (
    .clk(clk), .rst_n(rstn[3]), .req_valid(vld[3]), .req_ready(rdy[3]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[3]), .resp_rdata(rd3), .resp_err(re[3]));

  function automatic int lat_of(input int d);
    case (d)
      0: return 1;
      1: return 4;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [63:0] rdv(input int d);
    case (d)
      0: return {32'h0, rd0};
      1: return {32'h0, rd1};
      2: return {32'h0, rd2};
      default: return rd3;
    endcase
  endfunction

  // Reference: byte array, lowest address holds the most significant byte.
  function automatic logic [63:0] model(input int d, input bit wr, input logic [1:0] sz,
                                        input bit sg, input int a, input logic [63:0] wd,
                                        output bit err);
    int nb, n, base;
    logic [63:0] v, ones;
    nb  = (d == 3) ? 8 : 4;
    n   = 1 << sz;
    err = (n > nb) || (a % n != 0);
    if (err) return '0;
    v = '0;
    if (wr) begin
      for (int k = 0; k < n; k++) mref[d][a+k] = wd[8*(n-1-k) +: 8];
      base = a - (a % nb);
      for (int k = 0; k < nb; k++) v = (v << 8) | 64'(mref[d][base+k]);
      return v;
    end
    for (int k = 0; k < n; k++) v = (v << 8) | 64'(mref[d][a+k]);
    ones = '1;
    if (sg && n < 8 && v[8*n-1]) v = v | (ones << (8*n));
    if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                      input logic [11:0] a, input logic [63:0] wd,
                      output logic [63:0] rdata, output logic err, output int lat);
    int w;
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    vld[d] = 1'b1;
    w = 0;
    while (!rdy[d] && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    vld[d]     = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 12'($urandom);
    req_wdata  = {$urandom, $urandom};
    lat = 1;
    while (!rv[d] && lat < 20) begin @(negedge clk); lat++; end
    rdata = rdv(d);
    err   = re[d];
  endtask

  task automatic xchk(input string tag, input int d, input bit wr, input logic [1:0] sz,
                      input bit sg, input logic [11:0] a, input logic [63:0] wd,
                      input logic [63:0] exp_data, input logic exp_err);
    logic [63:0] r;
    logic e;
    int l;
    xact(d, wr, sz, sg, a, wd, r, e, l);
    check({tag, "_data"}, r, exp_data);
    check({tag, "_err"}, 64'(e), 64'(exp_err));
    check({tag, "_lat"}, 64'(l), 64'(lat_of(d)));
  endtask

  initial begin
    logic [63:0] r, wd, exp;
    logic        e;
    int          l, a, nb;
    bit          eerr, wr, sg;
    logic [1:0]  sz;

    vectors = 0; miscompares = 0;
    rstn = '1; vld = '0;
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #2 rstn = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(rdy), 64'hF);
    check("rst_valid", 64'(rv), 64'h0);
    check("rst_err", 64'(re), 64'h0);
    check("rst_rdata32", 64'(rd0 | rd1 | rd2), 64'h0);
    check("rst_rdata64", rd3, 64'h0);
    rstn = '1;
    @(negedge clk);
    check("rel_ready", 64'(rdy), 64'hF);

    // Back-to-back store then load on the single-cycle build
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 12'h010; req_wdata = 64'hDEADBEEF;
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_st_valid", 64'(rv[0]), 64'h1);
    check("t1_st_data", 64'(rd0), 64'hDEADBEEF);
    check("t1_st_err", 64'(re[0]), 64'h0);
    check("t1_ready", 64'(rdy[0]), 64'h1);
    req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    check("t1_ld_valid", 64'(rv[0]), 64'h1);
    check("t1_ld_data", 64'(rd0), 64'hDEADBEEF);
    check("t1_ld_err", 64'(re[0]), 64'h0);
    @(negedge clk);
    check("t1_pulse", 64'(rv[0]), 64'h0);

    xchk("t2_init", 0, 1, 2'b10, 0, 12'h010, 64'h11223344, 64'h11223344, 0);
    xchk("t2_stb", 0, 1, 2'b00, 0, 12'h013, 64'h80, 64'h11223380, 0);
    xchk("t2_ldsb", 0, 0, 2'b00, 1, 12'h013, 64'h0, 64'hFFFFFF80, 0);
    xchk("t2_ldub", 0, 0, 2'b00, 0, 12'h010, 64'h0, 64'h11, 0);
    xchk("t2_ldsh", 0, 0, 2'b01, 1, 12'h010, 64'h0, 64'h1122, 0);
    xchk("t3_ldh_mis", 0, 0, 2'b01, 0, 12'h011, 64'h0, 64'h0, 1);
    xchk("t3_stw_mis", 0, 1, 2'b10, 0, 12'h012, 64'hFFFFFFFF, 64'h0, 1);
    xchk("t3_unchanged", 0, 0, 2'b10, 0, 12'h010, 64'h0, 64'h11223380, 0);
    xchk("t3_dword32", 0, 0, 2'b11, 0, 12'h010, 64'h0, 64'h0, 1);

    // LATENCY=4: ready gap, held valid ignored, re-accepted in response cycle
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 12'h040; req_wdata = 64'hA5A5A5A5;
    vld[1] = 1'b1;
    check("t4_ready_c0", 64'(rdy[1]), 64'h1);
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) req_write = 1'b0;
      check("t4_ready_wait", 64'(rdy[1]), 64'h0);
      check("t4_valid_wait", 64'(rv[1]), 64'h0);
    end
    @(negedge clk);
    check("t4_valid_c4", 64'(rv[1]), 64'h1);
    check("t4_ready_c4", 64'(rdy[1]), 64'h1);
    check("t4_st_data", 64'(rd1), 64'hA5A5A5A5);
    check("t4_st_err", 64'(re[1]), 64'h0);
    @(posedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      if (c > 5) @(negedge clk);
      check("t4_ld_wait_valid", 64'(rv[1]), 64'h0);
      check("t4_ld_wait_ready", 64'(rdy[1]), 64'h0);
    end
    @(negedge clk);
    check("t4_ld_valid", 64'(rv[1]), 64'h1);
    check("t4_ld_data", 64'(rd1), 64'hA5A5A5A5);

    // LATENCY=3: reset during a pending load
    xchk("t5_st", 2, 1, 2'b10, 0, 12'h020, 64'hCAFEF00D, 64'hCAFEF00D, 0);
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_addr = 12'h020; vld[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[2] = 1'b0;
    rstn[2] = 1'b0;
    #1;
    check("t5_rst_valid", 64'(rv[2]), 64'h0);
    check("t5_rst_ready", 64'(rdy[2]), 64'h1);
    check("t5_rst_rdata", 64'(rd2), 64'h0);
    check("t5_rst_err", 64'(re[2]), 64'h0);
    @(negedge clk);
    rstn[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_no_pulse", 64'(rv[2]), 64'h0);
      check("t5_ready", 64'(rdy[2]), 64'h1);
    end
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 12'h024; req_wdata = 64'h5EED1234;
    vld[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[2] = 1'b0;
    rstn[2] = 1'b0;
    @(negedge clk);
    rstn[2] = 1'b1;
    xchk("t5_committed", 2, 0, 2'b10, 0, 12'h024, 64'h0, 64'h5EED1234, 0);

    xchk("t6_std", 3, 1, 2'b11, 0, 12'h008, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0);
    xchk("t6_ldsh", 3, 0, 2'b01, 1, 12'h00E, 64'h0, 64'hFFFFFFFFFFFFCDEF, 0);
    xchk("t6_lduw", 3, 0, 2'b10, 0, 12'h00C, 64'h0, 64'h0000000089ABCDEF, 0);
    xchk("t6_ldsw", 3, 0, 2'b10, 1, 12'h00C, 64'h0, 64'hFFFFFFFF89ABCDEF, 0);
    xchk("t6_ldsw_pos", 3, 0, 2'b10, 1, 12'h008, 64'h0, 64'h0000000001234567, 0);
    xchk("t6_dw_mis", 3, 0, 2'b11, 0, 12'h004, 64'h0, 64'h0, 1);

    // Randomized traffic over a fully initialised region of each build
    for (int d = 0; d < 4; d++) begin
      nb = (d == 3) ? 8 : 4;
      for (int k = 0; k < 64; k += nb) begin
        wd  = {$urandom, $urandom};
        sz  = (nb == 8) ? 2'b11 : 2'b10;
        exp = model(d, 1'b1, sz, 1'b0, 'h100 + k, wd, eerr);
        xact(d, 1'b1, sz, 1'b0, 12'('h100 + k), wd, r, e, l);
        check("rnd_init", r, exp);
      end
      repeat (40) begin
        wr  = 1'($urandom_range(0, 1));
        sz  = 2'($urandom_range(0, 3));
        sg  = 1'($urandom_range(0, 1));
        a   = 'h100 + int'($urandom_range(0, 63));
        wd  = {$urandom, $urandom};
        exp = model(d, wr, sz, sg, a, wd, eerr);
        xact(d, wr, sz, sg, 12'(a), wd, r, e, l);
        check("rnd_data", r, exp);
        check("rnd_err", 64'(e), 64'(eerr));
        check("rnd_lat", 64'(l), 64'(lat_of(d)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised successor data memory for the MIPS CPU MEM stage. It adds byte, halfword, word and (for 64-bit builds) doubleword loads and stores, big-endian byte lanes, and sign or zero extension on loads. Misaligned accesses are flagged. A valid/ready request handshake with a configurable fixed read/write latency lets the pipeline stall on a slow memory model. One access is outstanding at a time; the response returns on a single-cycle `resp_valid` pulse.

## Interface
- `DATA_BITS`, 32: word width; legal values 32 or 64.
- `ADDR_BITS`, 12: byte-address width; depth = 2**(ADDR_BITS-OFF) words, OFF = log2(DATA_BITS/8).
- `LATENCY`, 1: cycles from acceptance to response; legal range 1..8.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; transfer occurs when `req_valid && req_ready` at a rising edge.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_BITS=64).
- `req_signed` in 1: load sign-extends when 1, zero-extends when 0; ignored on stores.
- `req_addr` in ADDR_BITS: byte address.
- `req_wdata` in DATA_BITS: store data, right-justified (LSBs).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out DATA_BITS: load result; on a store, the full updated memory word.
- `resp_err` out 1: access was misaligned or used an illegal size.

## Operation
- Reset: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, state IDLE, counter 0. Memory contents are not reset (undefined).
- States:
  - IDLE: `req_ready`=1.
  - WAIT: `req_ready`=0; counter loaded with LATENCY-1 and decremented each cycle.
- Transitions:
  - IDLE→WAIT on acceptance, only when LATENCY>1.
  - WAIT→IDLE when the counter reaches 1; `resp_valid` is set at that same edge.
- Alignment:
  - Half is misaligned if addr[0]≠0. Word is misaligned if addr[1:0]≠0. Dword is misaligned if addr[2:0]≠0.
  - Size 11 with DATA_BITS=32 is illegal.
- Error access: memory is not modified, `resp_rdata`=0, `resp_err`=1. Timing is identical to a good access.
- Store: commits at the acceptance edge. Only the addressed byte lanes are written. Lane 0 (addr offset 0) is the MSB byte, i.e. big-endian.
- Load: the word is read at the acceptance edge and held in a capture register. At response time the addressed lanes are extracted, right-justified and extended according to `req_signed` as captured at acceptance.
- Request fields are captured at acceptance. Input changes after acceptance have no effect.
- Read-after-write to the same address returns the new data, because the write commits at an earlier edge.

## Timing
- Acceptance at edge E0: `resp_valid` is high in the cycle after edge E0+(LATENCY-1), for exactly one cycle.
- `req_ready` is low from after E0 until the edge that raises `resp_valid`. It is high during the `resp_valid` cycle.
- A new request may be accepted during the `resp_valid` cycle. For LATENCY=1 this gives one access per cycle.
- `resp_rdata` and `resp_err` are valid only while `resp_valid`=1. They hold their last value otherwise.
- Reset asserted mid-access: the pending response is dropped and all outputs return to reset values. A store accepted before reset stays committed.
- `req_valid` while `req_ready`=0 is ignored. No request is queued.

## Structure
- `data_mem_pkg` holds:
  - size encodings `SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD`;
  - state enum `IDLE/WAIT`;
  - a function computing OFF from DATA_BITS.
- Sub-module `data_mem_align` (combinational) handles:
  - misalign/illegal detection;
  - store lane-enable and lane-shift generation;
  - load extraction and extension.
- The top level holds the RAM array, capture registers, the latency counter and the FSM.

## Test plan
1. LATENCY=1, DATA_BITS=32: store word 0xDEADBEEF @0x010, then load word @0x010. Response: `resp_valid` one cycle after each accept, rdata=0xDEADBEEF, err=0. Back-to-back accepts with no ready gap.
2. Store byte 0x80 @0x013 over 0x11223344, then signed load byte @0x013. Store response rdata=0x11223380; load rdata=0xFFFFFF80. Unsigned load byte @0x010 returns 0x00000011.
3. Load half @0x011: err=1, rdata=0, memory unchanged. Store word @0x012: err=1, memory word @0x010 still 0x11223380.
4. LATENCY=4:
   - Accept at edge 0: ready low for cycles 1–3, `resp_valid` high in cycle 4 only, ready high in cycle 4.
   - `req_valid` held during cycles 1–3 is not accepted; it is accepted at the edge ending cycle 4.
5. LATENCY=3, deassert `rst_n` one cycle after a load accept: `resp_valid` never pulses; outputs at reset values; ready=1 after release.
6. DATA_BITS=64:
   - Store dword 0x0123456789ABCDEF @0x008, then load half signed @0x00E → 0xFFFFFFFFFFFFCDEF.
   - Size 11 on a DATA_BITS=32 build → err=1.
